agu_arbiter: RTL

AGU_ARBITER -- requirements
Module: agu_arbiter

---
 rtl/agu_arbiter.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/agu_arbiter.sv
// rtl/agu_arbiter.sv - round-robin arbiter sharing one address generation unit among NREQ requesters
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req[NREQ]                per-requester request, held until its done pulse
//   req_widen[NREQ]          per-requester widening flag
//   req_addr, req_max_reg    packed NREQ x ADDR_WIDTH base register / extra register count
//   req_off, req_max_off     packed NREQ x OFF_WIDTH start / final offset
//   gnt[NREQ]                one-hot, high for the granted requester's whole tenure
//   done[NREQ]               one-hot pulse when the granted requester's last address is accepted
//   agu_en, agu_*            AGU start command, valid only in the issue state
//   agu_idle, agu_addr_valid, agu_addr_end   AGU status
//   ack                      pipeline advance; issue/busy progress only when high
module agu_arbiter #(
    parameter int NREQ       = 4,
    parameter int ADDR_WIDTH = 5,
    parameter int OFF_WIDTH  = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NREQ-1:0]            req,
    input  logic [NREQ-1:0]            req_widen,
    input  logic [NREQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NREQ*ADDR_WIDTH-1:0] req_max_reg,
    input  logic [NREQ*OFF_WIDTH-1:0]  req_off,
    input  logic [NREQ*OFF_WIDTH-1:0]  req_max_off,
    output logic [NREQ-1:0]            gnt,
    output logic [NREQ-1:0]            done,
    output logic                       agu_en,
    output logic                       agu_widen,
    output logic [ADDR_WIDTH-1:0]      agu_addr,
    output logic [ADDR_WIDTH-1:0]      agu_max_reg,
    output logic [OFF_WIDTH-1:0]       agu_off,
    output logic [OFF_WIDTH-1:0]       agu_max_off,
    input  logic                       agu_idle,
    input  logic                       agu_addr_valid,
    input  logic                       agu_addr_end,
    input  logic                       ack
);

    localparam int IW = $clog2(NREQ);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_BUSY  = 2'd2
    } state_t;

    state_t                  state_q;
    logic [IW-1:0]           rr_q;
    // gnt_q doubles as the latched one-hot winner index
    logic [NREQ-1:0]         gnt_q;
    logic                    widen_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [ADDR_WIDTH-1:0]   max_reg_q;
    logic [OFF_WIDTH-1:0]    off_q;
    logic [OFF_WIDTH-1:0]    max_off_q;

    logic                    found;
    logic [IW-1:0]           win;
    logic                    finish;

    // Scan offsets from the far end down so the requester closest to rr_q wins.
    always_comb begin
        int c;
        c     = 0;
        found = 1'b0;
        win   = rr_q;
        for (int i = NREQ - 1; i >= 0; i--) begin
            c = int'(rr_q) + i;
            if (c >= NREQ) c = c - NREQ;
            if (req[IW'(c)]) begin
                found = 1'b1;
                win   = IW'(c);
            end
        end
    end

    // Last address of the tenure accepted by the pipeline this cycle.
    assign finish = ack && agu_addr_valid && agu_addr_end;

    assign gnt         = gnt_q;
    assign done        = (!rst && state_q != S_IDLE && finish) ? gnt_q : '0;
    assign agu_en      = (state_q == S_ISSUE);
    assign agu_widen   = widen_q;
    assign agu_addr    = addr_q;
    assign agu_max_reg = max_reg_q;
    assign agu_off     = off_q;
    assign agu_max_off = max_off_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            rr_q      <= '0;
            gnt_q     <= '0;
            widen_q   <= 1'b0;
            addr_q    <= '0;
            max_reg_q <= '0;
            off_q     <= '0;
            max_off_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // Selection does not wait for ack; only the AGU must be free.
                    if (found && agu_idle) begin
                        state_q   <= S_ISSUE;
                        gnt_q     <= NREQ'(1) << win;
                        rr_q      <= (win == IW'(NREQ - 1)) ? '0 : win + IW'(1);
                        widen_q   <= req_widen[win];
                        addr_q    <= req_addr[win*ADDR_WIDTH +: ADDR_WIDTH];
                        max_reg_q <= req_max_reg[win*ADDR_WIDTH +: ADDR_WIDTH];
                        off_q     <= req_off[win*OFF_WIDTH +: OFF_WIDTH];
                        max_off_q <= req_max_off[win*OFF_WIDTH +: OFF_WIDTH];
                    end
                end
                S_ISSUE: begin
                    if (ack) begin
                        if (agu_addr_valid && agu_addr_end) begin
                            state_q <= S_IDLE;
                            gnt_q   <= '0;
                        end else begin
                            state_q <= S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    if (finish) begin
                        state_q <= S_IDLE;
                        gnt_q   <= '0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    gnt_q   <= '0;
                end
            endcase
        end
    end

endmodule
